// File: rtl/restoring_divider_16bits.sv
// 16-bit unsigned restoring divider: one quotient bit per cycle, 16 iterations.
// Divide-by-zero short-circuits straight to DONE with saturated quotient.
module restoring_divider_16bits (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] q_q;
    logic [15:0] d_q;
    logic [16:0] r_q;
    logic [4:0]  cnt_q;
    logic [15:0] quot_q;
    logic [15:0] rem_q;
    logic        dbz_q;

    logic [16:0] r_shift;
    logic [16:0] t;
    logic [16:0] r_next;
    logic [15:0] q_next;
    logic        last_iter;
    logic        unused_r_msb;

    // R stays below D, so its top bit is never set between iterations.
    assign unused_r_msb = r_q[16];

    always_comb begin
        r_shift = {r_q[15:0], q_q[15]};
        t       = r_shift + ~{1'b0, d_q} + 17'd1;
        r_next  = r_shift;
        q_next  = {q_q[14:0], 1'b0};
        if (!t[16]) begin
            r_next = t;
            q_next = {q_q[14:0], 1'b1};
        end
    end

    assign last_iter = (cnt_q == 5'd15);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (divisor != 16'd0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (last_iter) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            q_q     <= 16'd0;
            d_q     <= 16'd0;
            r_q     <= 17'd0;
            cnt_q   <= 5'd0;
            quot_q  <= 16'd0;
            rem_q   <= 16'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        q_q   <= dividend;
                        d_q   <= divisor;
                        r_q   <= 17'd0;
                        cnt_q <= 5'd0;
                        if (divisor == 16'd0) begin
                            quot_q <= 16'hFFFF;
                            rem_q  <= dividend;
                            dbz_q  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    q_q   <= q_next;
                    r_q   <= r_next;
                    cnt_q <= cnt_q + 5'd1;
                    if (last_iter) begin
                        quot_q <= q_next;
                        rem_q  <= r_next[15:0];
                        dbz_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);

endmodule

// File: tb/tb_restoring_divider_16bits.sv
// Scoreboard bench for restoring_divider_16bits: directed vectors are queued on
// issue and a negedge monitor checks each done pulse against the queue.
module tb_restoring_divider_16bits;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = 16'd0;
    logic [15:0] divisor = 16'd0;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        int          acc;
        int          lat;
        int          bsy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_cnt = 0;

    restoring_divider_16bits dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (busy && done) chk("busy_done_overlap", 1, 0);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", int'(quotient), int'(e.q));
                    chk("remainder", int'(remainder), int'(e.r));
                    chk("div_by_zero", int'(div_by_zero), int'(e.dz));
                    chk("latency", cyc - e.acc + 1, e.lat);
                    chk("busy_cycles", busy_cnt, e.bsy);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic launch(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input bit push);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        if (push) begin
            e.q   = eq;
            e.r   = er;
            e.dz  = (b == 16'd0);
            e.acc = cyc;
            e.lat = (b == 16'd0) ? 1 : 17;
            e.bsy = (b == 16'd0) ? 0 : 16;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic hold_check(input logic [15:0] eq, input logic [15:0] er);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_quotient", int'(quotient), int'(eq));
        chk("hold_remainder", int'(remainder), int'(er));
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er);
        launch(a, b, eq, er, 1'b1);
        wait_done();
        hold_check(eq, er);
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_quotient"}, int'(quotient), 0);
        chk({tag, "_remainder"}, int'(remainder), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_dbz"}, int'(div_by_zero), 0);
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;

        repeat (3) @(posedge clk);
        #1;
        zero_check("reset");
        rst_n = 1'b1;

        run(16'd100, 16'd7, 16'd14, 16'd2);
        run(16'hFFFF, 16'd1, 16'hFFFF, 16'd0);
        run(16'd3, 16'd10, 16'd0, 16'd3);
        run(16'd5, 16'd0, 16'hFFFF, 16'd5);
        run(16'd0, 16'd5, 16'd0, 16'd0);
        run(16'd1234, 16'd1234, 16'd1, 16'd0);
        run(16'hFFFF, 16'hFFFF, 16'd1, 16'd0);
        run(16'hFFFF, 16'd256, 16'd255, 16'd255);
        run(16'd12345, 16'd123, 16'd100, 16'd45);
        run(16'd0, 16'd0, 16'hFFFF, 16'd0);

        // Start pulses and operand churn during RUN cycles 3-10 must be ignored.
        launch(16'd1000, 16'd9, 16'd111, 16'd1, 1'b1);
        repeat (2) @(posedge clk);
        for (int i = 3; i <= 10; i++) begin
            @(posedge clk); #1;
            start = (i % 2 == 1);
            dividend = 16'($urandom);
            divisor = 16'($urandom);
        end
        start = 1'b0;
        wait_done();
        hold_check(16'd111, 16'd1);

        // Abort mid-RUN: no done may follow, and outputs clear.
        launch(16'd60000, 16'd7, 16'd0, 16'd0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        zero_check("abort");
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        run(16'd40000, 16'd300, 16'd133, 16'd100);

        for (int i = 0; i < 200; i++) begin
            a = 16'($urandom);
            case (i % 4)
                0: b = 16'd1;
                1: b = a;
                2: b = 16'($urandom_range(1, 300));
                default: b = 16'($urandom);
            endcase
            if (i % 10 == 7) a = 16'd0;
            if (b == 16'd0) run(a, b, 16'hFFFF, a);
            else run(a, b, a / b, a % b);
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
